// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - field-to-Thumb instruction encoder with addressed 2-entry output FIFO
module instr_encode #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                PROG_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_reg1,
  input  logic [3:0]        in_reg2,
  input  logic [3:0]        in_reg3,
  input  logic [15:0]       in_offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic              err_illegal,
  output logic [7:0]        illegal_count
);
  localparam int WORDS_W = $clog2(PROG_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t              state;
  logic [1:0]          count;
  logic [15:0]         w0, w1;
  logic [ADDR_W-1:0]   a0, a1, addr;
  logic [WORDS_W-1:0]  words;
  logic [15:0]         enc_word;
  logic                enc_ok;
  logic [2:0]          rd;
  logic                accept, push, pop;

  assign rd = in_reg3[2:0];

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (in_opcode)
      4'd0:  begin enc_word = 16'hB580; enc_ok = (in_reg1 == 4'd7) && (in_reg2 == 4'd14); end
      4'd1:  begin enc_word = 16'hBD80; enc_ok = (in_reg1 == 4'd7) && (in_reg2 == 4'd14); end
      4'd2:  begin
        enc_word = 16'hB080 | {9'd0, in_offset[8:2]};
        enc_ok   = (in_reg1 == 4'd13) && (in_offset[1:0] == 2'd0) && (in_offset <= 16'd508);
      end
      4'd3:  begin enc_word = 16'h2800 | {5'd0, rd, in_offset[7:0]}; enc_ok = !in_reg3[3] && (in_offset <= 16'd255); end
      4'd4:  begin enc_word = 16'h2000 | {5'd0, rd, in_offset[7:0]}; enc_ok = !in_reg3[3] && (in_offset <= 16'd255); end
      4'd5:  begin enc_word = 16'h4680 | {10'd0, in_reg2[2:0], rd}; enc_ok = in_reg3[3] && !in_reg2[3]; end
      4'd6:  begin
        enc_word = 16'h4800 | {5'd0, rd, in_offset[9:2]};
        enc_ok   = (in_reg1 == 4'd15) && !in_reg3[3] && (in_offset[1:0] == 2'd0) && (in_offset <= 16'd1020);
      end
      4'd7:  begin
        enc_word = 16'h6000 | {5'd0, in_offset[4:0], in_reg2[2:0], rd};
        enc_ok   = (in_offset <= 16'd31) && !in_reg2[3] && !in_reg3[3];
      end
      4'd8:  begin
        enc_word = 16'h6800 | {5'd0, in_offset[4:0], in_reg2[2:0], rd};
        enc_ok   = (in_offset <= 16'd31) && !in_reg2[3] && !in_reg3[3];
      end
      4'd9:  begin
        enc_word = 16'hA800 | {5'd0, rd, in_offset[9:2]};
        enc_ok   = (in_reg1 == 4'd13) && !in_reg3[3] && (in_offset[1:0] == 2'd0) && (in_offset <= 16'd1020);
      end
      4'd10: begin enc_word = 16'hE000 | {6'd0, in_offset[10:1]}; enc_ok = !in_offset[0] && (in_offset <= 16'h07FE); end
      4'd11: begin
        enc_word = 16'h1C00 | {7'd0, in_offset[2:0], in_reg2[2:0], rd};
        enc_ok   = (in_offset <= 16'd7) && !in_reg2[3] && !in_reg3[3];
      end
      4'd12: begin enc_word = 16'hD000 | {4'd0, in_reg3, in_offset[7:0]}; enc_ok = (in_reg3 <= 4'd13) && (in_offset <= 16'd255); end
      4'd13: begin enc_word = 16'h5400 | {8'd0, in_offset[7:0]}; enc_ok = (in_offset <= 16'd255); end
      4'd14: begin enc_word = 16'h5C00 | {8'd0, in_offset[7:0]}; enc_ok = (in_offset <= 16'd255); end
      4'd15: begin
        enc_word = 16'h3000 | {5'd0, rd, in_offset[7:0]};
        enc_ok   = !in_reg3[3] && (in_offset <= 16'd255) && !in_offset[0];
      end
    endcase
  end

  // in_ready looks only at our own occupancy so a stalled consumer never creates a comb path
  assign in_ready  = (state == RUN) && (count < 2'd2) && !start;
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_ok;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_word  = w0;
  assign out_addr  = a0;
  assign done      = (state == FULL) && (count == 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 2'd0;
      w0            <= '0;
      w1            <= '0;
      a0            <= '0;
      a1            <= '0;
      addr          <= BASE_ADDR;
      words         <= '0;
      err_illegal   <= 1'b0;
      illegal_count <= '0;
    end else if (start) begin
      state       <= RUN;
      count       <= 2'd0;
      addr        <= BASE_ADDR;
      words       <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !enc_ok;
      if (accept && !enc_ok && (illegal_count != 8'hFF))
        illegal_count <= illegal_count + 8'd1;
      if (push) begin
        addr  <= addr + ADDR_W'(2);
        words <= words + 1'b1;
        // Leave RUN on the accept that completes the program so no extra word slips in
        if (words + 1'b1 == WORDS_W'(PROG_WORDS))
          state <= FULL;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            w0 <= enc_word;
            a0 <= addr;
          end else begin
            w1 <= enc_word;
            a1 <= addr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          w0    <= w1;
          a0    <= a1;
          count <= count - 2'd1;
        end
        2'b11: begin
          w0 <= enc_word;
          a0 <= addr;
        end
        default: ;
      endcase
    end
  end
endmodule
